// File: rtl/fp_vector_reduce.sv
// Pipelined floating-point sum of one NUM_INPUTS-wide vector per cycle,
// built as a fixed-pairing binary tree of LATENCY-deep fp_adder stages.

module fp_adder #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ready,
    output logic [WIDTH-1:0] o,
    output logic             valid
);
    localparam int EW  = (WIDTH == 64) ? 11 : ((WIDTH == 16) ? 5 : 8);
    localparam int MW  = WIDTH - 1 - EW;
    localparam int XW  = MW + 4;               // hidden + fraction + guard/round/sticky
    localparam int NW  = EW + 2;
    localparam int LZW = $clog2(XW + 1);

    logic             sa, sb, big_s, sml_s, op_sub, res_s;
    logic [EW-1:0]    ea, eb, big_e, sml_e;
    logic [MW-1:0]    fa, fb, big_f, sml_f, mant;
    logic             a_nan, b_nan, a_inf, b_inf, swap;
    logic [NW-1:0]    big_ee, sml_ee, diff, sh, e_n;
    logic [XW-1:0]    big_x, sml_x, sml_al, s_n;
    logic [XW:0]      sum;
    logic [LZW-1:0]   lz;
    logic             hid, g, r, st, rup, ovf;
    logic [EW+MW-1:0] mag;
    logic [WIDTH-1:0] res;

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;
    assign a_inf = (ea == '1) && (fa == '0);
    assign b_inf = (eb == '1) && (fb == '0);
    assign a_nan = (ea == '1) && (fa != '0);
    assign b_nan = (eb == '1) && (fb != '0);

    // Order operands by magnitude so the subtraction never goes negative.
    assign swap = {eb, fb} > {ea, fa};
    assign {big_s, big_e, big_f} = swap ? b : a;
    assign {sml_s, sml_e, sml_f} = swap ? a : b;
    assign op_sub = big_s ^ sml_s;

    assign big_ee = (big_e == '0) ? NW'(1) : {2'b00, big_e};
    assign sml_ee = (sml_e == '0) ? NW'(1) : {2'b00, sml_e};
    assign diff   = big_ee - sml_ee;
    assign big_x  = {big_e != '0, big_f, 3'b000};
    assign sml_x  = {sml_e != '0, sml_f, 3'b000};

    always_comb begin : align
        sml_al = '0;
        if (diff >= NW'(XW)) begin
            sml_al = {{(XW-1){1'b0}}, |sml_x};
        end else begin
            sml_al = (sml_x >> diff)
                   | {{(XW-1){1'b0}}, |(sml_x & ~({XW{1'b1}} << diff))};
        end
    end

    assign sum = op_sub ? ({1'b0, big_x} - {1'b0, sml_al})
                        : ({1'b0, big_x} + {1'b0, sml_al});

    always_comb begin : lzc
        lz = LZW'(XW);
        for (int i = 0; i < XW; i++) begin
            if (sum[i]) lz = LZW'(XW - 1 - i);
        end
    end

    // Left shifts stop at the minimum exponent so tiny results stay subnormal.
    always_comb begin : norm
        sh  = '0;
        s_n = '0;
        e_n = '0;
        if (sum[XW]) begin
            s_n = {sum[XW:2], sum[1] | sum[0]};
            e_n = big_ee + NW'(1);
        end else begin
            sh  = (NW'(lz) > big_ee - NW'(1)) ? big_ee - NW'(1) : NW'(lz);
            s_n = sum[XW-1:0] << sh;
            e_n = big_ee - sh;
        end
    end

    assign hid  = s_n[XW-1];
    assign mant = s_n[XW-2:3];
    assign g    = s_n[2];
    assign r    = s_n[1];
    assign st   = s_n[0];
    assign rup  = g & (r | st | mant[0]);
    assign ovf  = hid && (e_n >= {2'b00, {EW{1'b1}}});
    // Rounding carry ripples into the exponent field, reaching Inf when needed.
    assign mag  = {(hid ? e_n[EW-1:0] : {EW{1'b0}}), mant} + {{(EW+MW-1){1'b0}}, rup};
    assign res_s = (op_sub && (sum == '0)) ? 1'b0 : big_s;

    always_comb begin : special
        res = {res_s, mag};
        if (a_nan || b_nan || (a_inf && b_inf && op_sub)) begin
            res = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
        end else if (a_inf) begin
            res = a;
        end else if (b_inf) begin
            res = b;
        end else if (ovf) begin
            res = {big_s, {EW{1'b1}}, {MW{1'b0}}};
        end
    end

    logic [WIDTH-1:0]   d_pipe [LATENCY];
    logic [LATENCY-1:0] v_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_pipe <= '0;
            for (int i = 0; i < LATENCY; i++) d_pipe[i] <= '0;
        end else begin
            v_pipe[0] <= ready;
            d_pipe[0] <= res;
            for (int i = 1; i < LATENCY; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                d_pipe[i] <= d_pipe[i-1];
            end
        end
    end

    assign o     = d_pipe[LATENCY-1];
    assign valid = v_pipe[LATENCY-1];
endmodule

// Handshake: a is taken on every edge where ready=1 (no backpressure); valid=1
// marks the cycle carrying that vector's sum exactly D*LATENCY cycles later.
module fp_vector_reduce #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 5,
    parameter int LATENCY    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH*NUM_INPUTS-1:0] a,
    input  logic                        ready,
    output logic [WIDTH-1:0]            o,
    output logic                        valid
);
    localparam int D = $clog2(NUM_INPUTS);

    function automatic int lvl_n(input int l);
        int n;
        n = NUM_INPUTS;
        for (int k = 0; k < l; k++) n = (n + 1) / 2;
        return n;
    endfunction

    for (genvar l = 0; l < D; l++) begin : g_lvl
        localparam int N = lvl_n(l);
        localparam int P = N / 2;
        localparam int M = lvl_n(l + 1);

        logic [N*WIDTH-1:0] din;
        logic               din_v;
        logic [M*WIDTH-1:0] dout;
        logic [P-1:0]       dv;

        if (l == 0) begin : g_in
            assign din   = a;
            assign din_v = ready;
        end else begin : g_chain
            assign din   = g_lvl[l-1].dout;
            assign din_v = &g_lvl[l-1].dv;
        end

        // Fixed pairing (2j, 2j+1): the summation order is part of the result.
        for (genvar j = 0; j < P; j++) begin : g_add
            fp_adder #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_add (
                .clk   (clk),
                .rst   (rst),
                .a     (din[2*j*WIDTH +: WIDTH]),
                .b     (din[(2*j+1)*WIDTH +: WIDTH]),
                .ready (din_v),
                .o     (dout[j*WIDTH +: WIDTH]),
                .valid (dv[j])
            );
        end

        if (N % 2 == 1) begin : g_carry
            logic [WIDTH-1:0] dl [LATENCY];
            always_ff @(posedge clk) begin
                dl[0] <= din[(N-1)*WIDTH +: WIDTH];
                for (int i = 1; i < LATENCY; i++) dl[i] <= dl[i-1];
            end
            assign dout[P*WIDTH +: WIDTH] = dl[LATENCY-1];
        end
    end

    assign o     = g_lvl[D-1].dout;
    assign valid = &g_lvl[D-1].dv;
endmodule

// File: tb/tb_fp_vector_reduce.sv
// Bench for fp_vector_reduce: default 5-input build plus 2- and 8-input builds,
// with a cycle-exact scoreboard fed by a real-arithmetic reference model.

module tb_fp_vector_reduce;
    localparam int W   = 32;
    localparam int TOT = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [W*5-1:0] a5;
    logic           r5, v5;
    logic [W-1:0]   o5;
    logic [W*2-1:0] a2;
    logic           r2, v2;
    logic [W-1:0]   o2;
    logic [W*8-1:0] a8;
    logic           r8, v8;
    logic [W-1:0]   o8;

    fp_vector_reduce #(.WIDTH(W), .NUM_INPUTS(5), .LATENCY(8)) dut5 (
        .clk(clk), .rst(rst), .a(a5), .ready(r5), .o(o5), .valid(v5));
    fp_vector_reduce #(.WIDTH(W), .NUM_INPUTS(2), .LATENCY(8)) dut2 (
        .clk(clk), .rst(rst), .a(a2), .ready(r2), .o(o2), .valid(v2));
    fp_vector_reduce #(.WIDTH(W), .NUM_INPUTS(8), .LATENCY(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .ready(r8), .o(o8), .valid(v8));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: exact real arithmetic on integer-valued operands.
    function automatic logic [31:0] to_f32(input real x);
        logic [63:0] d;
        d = $realtobits(x);
        if (x == 0.0) return 32'h0;
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    function automatic real from_f32(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'h0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] ref_sum(input logic [W*5-1:0] vec);
        real s;
        s = 0.0;
        for (int i = 0; i < 5; i++) s += from_f32(vec[i*W +: W]);
        return to_f32(s);
    endfunction

    function automatic logic [W*5-1:0] rand_vec();
        logic [W*5-1:0] v;
        for (int i = 0; i < 5; i++) begin
            int k;
            k = int'($urandom_range(0, 2000000)) - 1000000;
            v[i*W +: W] = to_f32(real'(k));
        end
        return v;
    endfunction

    logic [W-1:0] exp_q[$];
    int           exp_cyc[$];

    // Driver: one call per cycle; inputs change 1 time unit after the edge.
    task automatic step5(input bit rst_v, input bit rdy, input logic [W*5-1:0] vec,
                         input logic [W-1:0] exp);
        @(posedge clk);
        #1;
        rst = rst_v;
        r5  = rdy;
        a5  = vec;
        if (rst_v) begin
            while (exp_cyc.size() > 0 && exp_cyc[$] > cyc) begin
                void'(exp_cyc.pop_back());
                void'(exp_q.pop_back());
            end
        end else if (rdy) begin
            exp_q.push_back(exp);
            exp_cyc.push_back(cyc + TOT);
        end
    endtask

    task automatic idle5(input int n);
        for (int i = 0; i < n; i++) step5(1'b0, 1'b0, rand_vec(), '0);
    endtask

    always @(negedge clk) begin
        if (exp_cyc.size() > 0 && exp_cyc[0] == cyc) begin
            check("valid5", {31'b0, v5}, 1);
            check("o5", o5, exp_q[0]);
            void'(exp_cyc.pop_front());
            void'(exp_q.pop_front());
        end else begin
            check("valid5_idle", {31'b0, v5}, 0);
        end
    end

    initial begin
        logic [W*5-1:0] vec;
        int             start, seen;
        logic [W-1:0]   got_o;

        rst = 1'b1; r5 = 1'b0; a5 = '0;
        r2 = 1'b0; a2 = '0; r8 = 1'b0; a8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_o5", o5, 0);
        check("rst_v2", {31'b0, v2}, 0);
        check("rst_v8", {31'b0, v8}, 0);

        // First cycle out of reset carries the {1,2,3,4,5} vector.
        vec = {32'h40A00000, 32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        check("ref_15", ref_sum(vec), 32'h41700000);
        step5(1'b0, 1'b1, vec, 32'h41700000);
        idle5(30);

        for (int k = 1; k <= 10; k++) begin
            for (int i = 0; i < 5; i++) vec[i*W +: W] = to_f32(real'(k));
            step5(1'b0, 1'b1, vec, ref_sum(vec));
        end
        idle5(30);

        for (int i = 0; i < 5; i++) begin
            bit p;
            p = (i == 0) || (i == 2) || (i == 3);
            vec = rand_vec();
            step5(1'b0, p, vec, ref_sum(vec));
        end
        idle5(30);

        vec = {32'h0, 32'h0, to_f32(1.0), to_f32(-1.0e8), to_f32(1.0e8)};
        step5(1'b0, 1'b1, vec, 32'h3F800000);
        idle5(30);

        for (int i = 0; i < 200; i++) begin
            vec = rand_vec();
            if ($urandom_range(0, 7) == 0) vec[W +: W] = vec[0 +: W] ^ 32'h80000000;
            step5(1'b0, $urandom_range(0, 3) != 0, vec, ref_sum(vec));
        end
        idle5(30);

        for (int i = 0; i < 4; i++) begin
            vec = rand_vec();
            step5(1'b0, 1'b1, vec, ref_sum(vec));
        end
        idle5(10);
        step5(1'b1, 1'b1, rand_vec(), '0);
        idle5(40);
        vec = rand_vec();
        step5(1'b0, 1'b1, vec, ref_sum(vec));
        idle5(30);

        @(posedge clk);
        #1;
        a2 = {to_f32(2.5), to_f32(1.5)};
        r2 = 1'b1;
        start = cyc;
        @(posedge clk);
        #1;
        r2 = 1'b0;
        seen = -1; got_o = '0;
        for (int i = 0; i < 40 && seen < 0; i++) begin
            @(negedge clk);
            if (v2) begin seen = cyc; got_o = o2; end
        end
        check("lat2", 32'(seen - start), 8);
        check("o2", got_o, 32'h40800000);

        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) a8[i*W +: W] = to_f32(1.0);
        r8 = 1'b1;
        start = cyc;
        @(posedge clk);
        #1;
        r8 = 1'b0;
        seen = -1; got_o = '0;
        for (int i = 0; i < 60 && seen < 0; i++) begin
            @(negedge clk);
            if (v8) begin seen = cyc; got_o = o8; end
        end
        check("lat8", 32'(seen - start), 24);
        check("o8", got_o, 32'h41000000);

        idle5(5);
        check("drain", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_vector_reduce.md
FP_VECTOR_REDUCE -- requirements
Module: fp_vector_reduce

Interface
REQ-001 Parameter WIDTH, default 32, floating-point word width in bits (IEEE-754 single when 32).
REQ-002 Parameter NUM_INPUTS, default 5, number of elements per input vector; legal range 2..64.
REQ-003 Parameter LATENCY, default 8, cycles per fp_adder stage.
REQ-004 Port clk  input  1  sole clock; all logic on rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port a  input  WIDTH*NUM_INPUTS  packed vector; element i at a[(i+1)*WIDTH-1:i*WIDTH].
REQ-007 Port ready  input  1  input strobe; a is sampled on every cycle ready=1.
REQ-008 Port o  output  WIDTH  reduced sum of one input vector.
REQ-009 Port valid  output  1  o holds a result this cycle.

Function
REQ-010 The block SHALL compute o = sum of all NUM_INPUTS elements of one sampled vector, as a pipelined binary adder tree of fp_adder instances (ports clk, rst, a, b, o, ready, valid; parameters WIDTH, LATENCY).
REQ-011 Tree depth SHALL be D = ceil(log2(NUM_INPUTS)); total latency SHALL be exactly D*LATENCY cycles from the sampling edge (ready=1) to the edge at which valid=1 with that vector's sum.
REQ-012 Pairing SHALL be fixed: at each level, operand j pairs with operand j+1 for even j (0+1, 2+3, ...); the order is bit-exact and normative because FP addition is non-associative.
REQ-013 An unpaired last operand at any level SHALL be carried to the next level through a LATENCY-deep register delay line, aligned with that level's adder outputs.
REQ-014 Throughput SHALL be one vector per cycle; ready may be 1 on consecutive cycles with no bubbles, and results SHALL emerge in input order, one per cycle.
REQ-015 ready=0 cycles SHALL propagate as bubbles: valid=0 exactly D*LATENCY cycles later; no backpressure exists.
REQ-016 valid SHALL be driven from a D*LATENCY-deep valid shift register (or equivalently the final-level adder valid), never from a counter, so overlapping vectors are tracked individually.
REQ-017 o SHALL be don't-care when valid=0; verification checks o only when valid=1.
REQ-018 Delay-line data registers SHALL need no reset; only valid-tracking state is reset.
REQ-019 NUM_INPUTS=2 SHALL give D=1 with no delay lines; power-of-two NUM_INPUTS SHALL give no delay lines.
REQ-020 Special values (NaN, Inf, zero signs, rounding) SHALL be exactly those produced by fp_adder; the block adds no arithmetic of its own.

Reset
REQ-021 While rst=1, valid SHALL be 0 on the next edge and stay 0; o resets to 0.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight vectors; no valid=1 SHALL appear for any vector sampled before or during reset.
REQ-023 A vector sampled on the first cycle with rst=0 SHALL produce valid=1 exactly D*LATENCY cycles later.

Verification (WIDTH=32, NUM_INPUTS=5, LATENCY=8, D=3, latency 24)
REQ-024 Single vector {1.0,2.0,3.0,4.0,5.0} (0x3F800000,0x40000000,0x40400000,0x40800000,0x40A00000), ready=1 for 1 cycle at cycle T -> valid=1 only at T+24, o=0x41700000 (15.0).
REQ-025 Back-to-back: 10 consecutive ready=1 vectors, vector k all elements = k.0 -> valid=1 for 10 consecutive cycles starting T+24, o = 5k.0 in order.
REQ-026 Bubbles: ready pattern 1,0,1,1,0 -> valid pattern 1,0,1,1,0 delayed by exactly 24 cycles.
REQ-027 Pairing order: elements {1.0e8, -1.0e8, 1.0, 0, 0} -> o=0x3F800000 (1.0), proving (e0+e1) is formed before adding e2.
REQ-028 Reset mid-flight: ready=1 for 4 cycles, rst=1 for 1 cycle 10 cycles later -> valid remains 0 for 40 cycles after; a new vector after reset returns after exactly 24 cycles.
REQ-029 NUM_INPUTS=2 and NUM_INPUTS=8 builds: {1.5,2.5} -> 4.0 (0x40800000) after 8 cycles; eight 1.0 -> 8.0 (0x41000000) after 24 cycles.
